// File: rtl/includes.sv
// Shared constants and types for the interrupt controller.
package includes;

  localparam int W_HINT = 6;

  localparam logic [1:0] INTR_A_TRIG = 2'd0;
  localparam logic [1:0] INTR_A_PEND = 2'd1;
  localparam logic [1:0] INTR_A_CMP  = 2'd2;
  localparam logic [1:0] INTR_A_CNT  = 2'd3;

  typedef struct packed {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } intr_cfg_t;

endpackage

// File: rtl/intr_ctrl_sync.sv
// One external line: SYNC_STAGES-deep synchroniser plus a delay flop for rise detection.
module intr_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   p_q, p_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], d};
    p_d     = chain_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
      p_q     <= 1'b0;
    end else begin
      chain_q <= chain_d;
      p_q     <= p_d;
    end
  end

  assign s    = chain_q[SYNC_STAGES-1];
  assign rise = s & ~p_q;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt source controller feeding CP0 Cause IP7..IP2.
// Count/Compare timer is built only when INTR_TIMER_EN is defined.
module intr_ctrl
  import includes::*;
#(
  parameter int N_EXT       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_EXT-1:0]  ext_irq,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic [W_HINT-1:0] hard_intr
);

  intr_cfg_t cfg;
  assign cfg.we    = cfg_we;
  assign cfg.addr  = cfg_addr;
  assign cfg.wdata = cfg_wdata;

  logic [N_EXT-1:0] s, rise;

  for (genvar i = 0; i < N_EXT; i++) begin : g_sync
    intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (ext_irq[i]),
      .s    (s[i]),
      .rise (rise[i])
    );
  end

  logic [N_EXT-1:0] trig_q, trig_d;
  logic [N_EXT-1:0] pend_q, pend_d;
  logic [N_EXT-1:0] clr;
  logic             trig_wr;
  logic             tpend;

  always_comb begin
    trig_wr = cfg.we && (cfg.addr == INTR_A_TRIG);
    clr     = (cfg.we && (cfg.addr == INTR_A_PEND)) ? cfg.wdata[N_EXT-1:0] : '0;
    trig_d  = trig_wr ? cfg.wdata[N_EXT-1:0] : trig_q;
    // Edge bits hold until cleared, a new rise beating a same-cycle clear.
    pend_d  = (trig_q & ((pend_q & ~clr) | rise)) | (~trig_q & s);
    if (trig_wr) begin
      pend_d = pend_d & ~(trig_q ^ trig_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q <= '0;
      pend_q <= '0;
    end else begin
      trig_q <= trig_d;
      pend_q <= pend_d;
    end
  end

`ifdef INTR_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] count_inc;
  logic        tpend_q, tpend_d;
  logic        cnt_wr, cmp_wr;

  always_comb begin
    cnt_wr    = cfg.we && (cfg.addr == INTR_A_CNT);
    cmp_wr    = cfg.we && (cfg.addr == INTR_A_CMP);
    count_inc = count_q + 32'd1;
    count_d   = cnt_wr ? cfg.wdata : count_inc;
    cmp_d     = cmp_wr ? cfg.wdata : cmp_q;
    tpend_d   = tpend_q;
    // Only a real increment can match; a COMPARE write always clears.
    if (cmp_wr) begin
      tpend_d = 1'b0;
    end else if (!cnt_wr && (count_inc == cmp_q)) begin
      tpend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      cmp_q   <= '0;
      tpend_q <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      tpend_q <= tpend_d;
    end
  end

  assign tpend = tpend_q;
`else
  logic unused_wdata;
  assign unused_wdata = ^cfg.wdata[31:N_EXT];
  assign tpend        = 1'b0;
`endif

  assign hard_intr = {tpend, pend_q};

  always_comb begin
    cfg_rdata = '0;
    case (cfg.addr)
      INTR_A_TRIG: cfg_rdata = {{(32-N_EXT){1'b0}}, trig_q};
      INTR_A_PEND: cfg_rdata = {{(32-W_HINT){1'b0}}, hard_intr};
`ifdef INTR_TIMER_EN
      INTR_A_CMP:  cfg_rdata = cmp_q;
      INTR_A_CNT:  cfg_rdata = count_q;
`endif
      default:     cfg_rdata = '0;
    endcase
  end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt source controller that produces the hardware interrupt vector consumed by the CP0 Cause register (`hard_intr`, IP7..IP2). It synchronises five asynchronous external interrupt lines, latches them as level- or edge-triggered per line, and hosts the free-running Count/Compare timer whose match drives the highest line. A small register port lets the memory-mapped peripheral bus configure trigger modes, clear latched edges and program the timer.

## Interface
- `N_EXT`, 5: external interrupt lines, mapped to `hard_intr[N_EXT-1:0]`.
- `SYNC_STAGES`, 2: synchroniser depth per external line; minimum 2.

- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ext_irq` in N_EXT: raw asynchronous interrupt requests, active-high.
- `cfg_we` in 1: register write strobe, one cycle per write.
- `cfg_addr` in 2: register select. 0 = TRIGGER, 1 = PENDING, 2 = COMPARE, 3 = COUNT.
- `cfg_wdata` in 32: write data.
- `cfg_rdata` out 32: combinational read of the register at `cfg_addr`.
- `hard_intr` out `W_HINT` (6): pending vector to CP0. Bit 5 is the timer. Bits 4..0 are external.

## Operation
- Each `ext_irq[i]` passes through a SYNC_STAGES flop chain to give `s[i]`. `p[i]` is `s[i]` delayed by one flop.
- TRIGGER[i] = 0 selects level mode: `pend[i] <= s[i]` every cycle.
- TRIGGER[i] = 1 selects edge mode: `pend[i] <= (pend[i] & ~clr[i]) | (s[i] & ~p[i])`.
- `clr` is `cfg_wdata[4:0]` when `cfg_we` is high and `cfg_addr` = 1, else 0.
- PENDING write is write-1-to-clear. It affects only edge-mode bits.
- A new edge and a clear on the same bit in the same cycle: set wins.
- A TRIGGER write clears `pend` for every bit whose mode changes. `p` is unaffected.
- Timer: COUNT increments by 1 every cycle and wraps from 32'hFFFFFFFF to 0 with no extra event.
- A COUNT write loads `cfg_wdata` instead of incrementing.
- `tpend` sets on the cycle COUNT increments into a value equal to COMPARE. A load via COUNT write never sets it.
- A COMPARE write loads COMPARE and clears `tpend`. If a match occurs in the same cycle, the clear wins.
- `hard_intr = {tpend, pend}` is driven directly from flops with no combinational path.
- Read data:
  - TRIGGER reads `{27'b0, trig}`.
  - PENDING reads `{26'b0, hard_intr}`.
  - COMPARE and COUNT read their register values.
- Writes to PENDING bit 5 are ignored.

## Timing
- Reset values: all sync flops, `p`, `pend`, `tpend`, TRIGGER, COMPARE and COUNT are 0.
  - Therefore `hard_intr` = 0 during and after reset.
  - `cfg_rdata` follows `cfg_addr` combinationally; it reads 0 for every address in reset.
- External latency with SYNC_STAGES = 2: with `ext_irq` high before edge k, `s` is high after edge k+1 and `hard_intr[i]` after edge k+2.
  - This holds for both level and edge mode.
  - Deassertion in level mode has the same latency.
- Edge mode needs a high pulse of at least one full cycle to be guaranteed captured.
- Register writes take effect at the clock edge ending the `cfg_we` cycle. `hard_intr` reflects a clear one cycle later.
- Timer: after COMPARE = C is written and the count increments to C, `hard_intr[5]` is high on the following cycle.
- Asserting `rst` at any point asynchronously returns all state to reset values. No pending event survives reset.

## Configuration
- `INTR_TIMER_EN` defined: timer present as described.
- `INTR_TIMER_EN` undefined:
  - No COUNT, COMPARE or `tpend` flops.
  - `hard_intr[5]` is tied to 0.
  - Addresses 2 and 3 read 0, and writes to them are ignored.

## Structure
- Shared package `includes`:
  - Reuse `W_HINT`.
  - Add `INTR_A_TRIG`, `INTR_A_PEND`, `INTR_A_CMP` and `INTR_A_CNT` as 2-bit address constants.
  - Add an `intr_cfg_t` struct {we, addr, wdata}.
- Sub-module `intr_sync`: a per-line parameterised synchroniser plus `p` flop.
  - Outputs `s` and `rise = s & ~p`.
  - Instantiated N_EXT times.

## Test plan
- Reset then `ext_irq` = 5'b00001 held (level) -> `hard_intr` = 6'b000001 exactly 3 edges after the input rises. Drop the input -> 0 after the same latency.
- TRIGGER = 5'b00010, then a 1-cycle pulse on `ext_irq[1]` -> `hard_intr[1]` stays 1 after the pulse ends. PENDING write 32'h2 -> `hard_intr[1]` = 0 next cycle.
- Edge on bit 1 in the same cycle as PENDING W1C of bit 1 -> `hard_intr[1]` stays 1.
- COUNT = 32'h10, COMPARE = 32'h18 -> `hard_intr[5]` rises after the count reaches 32'h18. COMPARE write -> `hard_intr[5]` = 0. COUNT write of 32'h18 -> no timer interrupt.
- COUNT = 32'hFFFFFFFE, COMPARE = 32'h1 -> wraps through 0, timer fires at 1 only.
- `rst` asserted mid-operation with pending bits set -> `hard_intr` = 0 immediately, asynchronously. Build without `INTR_TIMER_EN` -> `cfg_rdata` = 0 at addresses 2 and 3.
